// File: rtl/minesweeper_pkg.sv
// Shared definitions for the minesweeper cell-state sequencing logic:
// grid geometry, cell word layout, sequencer states and neighbour offsets.
package minesweeper_pkg;

    localparam int GRID_W = 16;
    localparam int GRID_H = 16;

    // Cell word layout
    localparam int MINE_B  = 0;
    localparam int REV_B   = 1;
    localparam int FLAG_B  = 2;
    localparam int ADJ_LSB = 3;
    localparam int ADJ_MSB = 6;

    typedef logic [6:0] cell_t;

    localparam cell_t REV_MASK  = 7'b000_0010;
    localparam cell_t FLAG_MASK = 7'b000_0100;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        T_RD   = 3'd1,
        T_CHK  = 3'd2,
        POP    = 3'd3,
        NB_RD  = 3'd4,
        NB_CHK = 3'd5,
        DONE   = 3'd6
    } seq_state_e;

    // Neighbour slots in scan order: row above, same row, row below
    typedef logic signed [1:0] offs_t;
    localparam offs_t NB_DX [8] = '{-2'sd1,  2'sd0,  2'sd1, -2'sd1,  2'sd1, -2'sd1,  2'sd0,  2'sd1};
    localparam offs_t NB_DY [8] = '{-2'sd1, -2'sd1, -2'sd1,  2'sd0,  2'sd0,  2'sd1,  2'sd1,  2'sd1};

    // Offset a 4-bit coordinate; bit 4 of the result flags an off-grid position
    // (0-1 wraps to 31, 15+1 gives 16).
    function automatic logic [4:0] step_coord(input logic [3:0] c, input offs_t d);
        return {1'b0, c} + {{3{d[1]}}, d};
    endfunction

endpackage

// File: rtl/cell_fifo.sv
// Synchronous first-word-fall-through FIFO holding cell addresses awaiting
// neighbour expansion. Single-cycle flush empties it.
module cell_fifo #(
    parameter int DEPTH = 256,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_data_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    // Storage array; contents need no reset because empty gates every read
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer and occupancy tracking, cleared by reset or flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign empty_o    = (count_q == '0);

endmodule

// File: rtl/reveal_sequencer.sv
// Sequences all cell-state RAM accesses for reveal / toggle-flag commands,
// expanding zero-adjacency reveals with a breadth-first flood fill, and
// keeps the game-over, win and revealed-count status.
module reveal_sequencer
    import minesweeper_pkg::*;
#(
    parameter int NUM_MINES = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_op,
    input  logic [3:0] cmd_x,
    input  logic [3:0] cmd_y,
    output logic [7:0] ram_addr,
    output logic       ram_we,
    output logic [6:0] ram_wdata,
    input  logic [6:0] ram_rdata,
    output logic       busy,
    output logic       done,
    output logic       game_over,
    output logic       win,
    output logic [8:0] revealed_cnt
);
    localparam logic [8:0] WIN_CNT = 9'(GRID_W * GRID_H - NUM_MINES);

    seq_state_e state_q;
    logic [7:0] cur_addr_q;
    logic       op_q;
    logic [2:0] nb_q;
    logic       game_over_q;
    logic       win_q;
    logic [8:0] cnt_q;

    logic [4:0] nb_x_s;
    logic [4:0] nb_y_s;
    logic       nb_ok_s;
    logic [7:0] nb_addr_s;
    logic       rd_mine_s, rd_rev_s, rd_flag_s, rd_adj0_s;

    logic [7:0] ram_addr_s;
    logic       ram_we_s;
    cell_t      ram_wdata_s;
    logic       push_s;
    logic       inc_s;
    logic       mine_hit_s;
    logic       pop_s;
    logic [7:0] fifo_data_s;
    logic       fifo_empty_s;

    assign nb_x_s    = step_coord(cur_addr_q[3:0], NB_DX[nb_q]);
    assign nb_y_s    = step_coord(cur_addr_q[7:4], NB_DY[nb_q]);
    assign nb_ok_s   = !nb_x_s[4] && !nb_y_s[4];
    assign nb_addr_s = {nb_y_s[3:0], nb_x_s[3:0]};

    assign rd_mine_s = ram_rdata[MINE_B];
    assign rd_rev_s  = ram_rdata[REV_B];
    assign rd_flag_s = ram_rdata[FLAG_B];
    assign rd_adj0_s = (ram_rdata[ADJ_MSB:ADJ_LSB] == 4'd0);

    // RAM access decode and per-cycle actions from the current state
    always_comb begin
        ram_addr_s  = 8'd0;
        ram_we_s    = 1'b0;
        ram_wdata_s = 7'd0;
        push_s      = 1'b0;
        inc_s       = 1'b0;
        mine_hit_s  = 1'b0;
        case (state_q)
            T_RD: begin
                ram_addr_s = cur_addr_q;
            end
            T_CHK: begin
                ram_addr_s = cur_addr_q;
                if (op_q) begin
                    if (!rd_rev_s) begin
                        ram_we_s    = 1'b1;
                        ram_wdata_s = ram_rdata ^ FLAG_MASK;
                    end else begin
                        ram_we_s    = 1'b0;
                    end
                end else if (rd_rev_s || rd_flag_s) begin
                    ram_we_s = 1'b0;
                end else if (rd_mine_s) begin
                    ram_we_s    = 1'b1;
                    ram_wdata_s = ram_rdata | REV_MASK;
                    mine_hit_s  = 1'b1;
                end else begin
                    ram_we_s    = 1'b1;
                    ram_wdata_s = ram_rdata | REV_MASK;
                    inc_s       = 1'b1;
                    push_s      = rd_adj0_s;
                end
            end
            NB_RD: begin
                ram_addr_s = nb_ok_s ? nb_addr_s : cur_addr_q;
            end
            NB_CHK: begin
                ram_addr_s = nb_ok_s ? nb_addr_s : cur_addr_q;
                if (nb_ok_s && !rd_rev_s && !rd_flag_s && !rd_mine_s) begin
                    ram_we_s    = 1'b1;
                    ram_wdata_s = ram_rdata | REV_MASK;
                    inc_s       = 1'b1;
                    push_s      = rd_adj0_s;
                end else begin
                    ram_we_s    = 1'b0;
                end
            end
            default: begin
                ram_addr_s = 8'd0;
            end
        endcase
    end

    // new_game suppresses any write or FIFO activity in its cycle
    assign ram_addr     = ram_addr_s;
    assign ram_we       = ram_we_s & ~new_game;
    assign ram_wdata    = ram_wdata_s;
    assign pop_s        = (state_q == POP) && !fifo_empty_s && !new_game;

    assign cmd_ready    = (state_q == IDLE) && !game_over_q && !win_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign game_over    = game_over_q;
    assign win          = win_q;
    assign revealed_cnt = cnt_q;

    cell_fifo #(
        .DEPTH (GRID_W * GRID_H),
        .W     (8)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (new_game),
        .push_i      (push_s & ~new_game),
        .push_data_i ((state_q == T_CHK) ? cur_addr_q : nb_addr_s),
        .pop_i       (pop_s),
        .pop_data_o  (fifo_data_s),
        .empty_o     (fifo_empty_s)
    );

    // Sequencer FSM and sticky game status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= 8'd0;
            op_q        <= 1'b0;
            nb_q        <= 3'd0;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
            cnt_q       <= 9'd0;
        end else if (new_game) begin
            state_q     <= IDLE;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
            cnt_q       <= 9'd0;
        end else begin
            if (inc_s) begin
                cnt_q <= cnt_q + 9'd1;
            end
            game_over_q <= game_over_q | mine_hit_s;
            win_q       <= win_q | (cnt_q == WIN_CNT);
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cur_addr_q <= {cmd_y, cmd_x};
                        op_q       <= cmd_op;
                        state_q    <= T_RD;
                    end
                end
                T_RD: begin
                    state_q <= T_CHK;
                end
                T_CHK: begin
                    state_q <= push_s ? POP : DONE;
                end
                POP: begin
                    if (fifo_empty_s) begin
                        state_q <= DONE;
                    end else begin
                        cur_addr_q <= fifo_data_s;
                        nb_q       <= 3'd0;
                        state_q    <= NB_RD;
                    end
                end
                NB_RD: begin
                    state_q <= NB_CHK;
                end
                NB_CHK: begin
                    nb_q    <= nb_q + 3'd1;
                    state_q <= (nb_q == 3'd7) ? POP : NB_RD;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/reveal_sequencer.md
# reveal_sequencer

Sequences every access to the 16x16 cell-state RAM on behalf of the cursor/select front end. It accepts one command at a time (reveal or toggle-flag at a grid coordinate). Reveals of zero-adjacency cells are expanded with a breadth-first flood fill over an internal address FIFO. The block also maintains the game-over, win and revealed-count status that the VGA renderer and top-level game FSM consume.

## Interface
- NUM_MINES, 40, mines on the board; the win threshold is 256-NUM_MINES.
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- new_game  in  1  one-cycle pulse; clears status and aborts any operation
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE with game_over=0 and win=0
- cmd_op  in  1  0=reveal, 1=toggle flag
- cmd_x, cmd_y  in  4 each  target cell column and row
- ram_addr  out  8  {y,x}
- ram_we  out  1  write strobe
- ram_wdata  out  7  cell word
- ram_rdata  in  7  cell word, valid the cycle after ram_addr is presented (synchronous read)
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse when a command completes
- game_over  out  1  sticky; set when a mine is revealed
- win  out  1  sticky; set when revealed_cnt == 256-NUM_MINES
- revealed_cnt  out  9  number of revealed safe cells

## Operation
- Cell word layout: bit0 mine, bit1 revealed, bit2 flagged, bits[6:3] adjacency count (0..8).
- States: IDLE, T_RD, T_CHK, POP, NB_RD, NB_CHK, DONE.
- IDLE: when cmd_valid && cmd_ready, latch cur_addr={cmd_y,cmd_x} and cmd_op, then go to T_RD. Commands are ignored while cmd_ready is 0.
- T_RD: ram_addr=cur_addr. Go to T_CHK.
- T_CHK, flag op: if the cell is not revealed, write the word with bit2 inverted. Go to DONE.
- T_CHK, reveal op:
  - Cell revealed or flagged: no write; go to DONE.
  - Cell is a mine: write revealed, set game_over; go to DONE.
  - Otherwise: write revealed and increment revealed_cnt. If adjacency is 0, push cur_addr and go to POP; else go to DONE.
- POP: if the FIFO is empty, go to DONE. Otherwise pop into cur_addr, set nb=0, go to NB_RD.
- NB_RD/NB_CHK run once per neighbour slot nb=0..7, in order (-1,-1),(0,-1),(+1,-1),(-1,0),(+1,0),(-1,+1),(0,+1),(+1,+1):
  - An out-of-range slot (coordinate <0 or >15) still takes 2 cycles, with no RAM access and no write.
  - For an in-range slot, NB_CHK writes revealed and increments revealed_cnt only if the cell is not revealed, not flagged and not a mine. If that cell's adjacency is also 0, it is pushed.
  - After nb=7, go to POP.
- DONE: done=1 for one cycle, then go to IDLE.
- win is evaluated on the registered revealed_cnt; it sets the cycle after the count reaches the threshold.
- FIFO is 256 x 8. A cell is marked revealed in the same cycle it is pushed, so it is pushed at most once; full therefore cannot occur, and overflow needs no handling.
- new_game has priority over everything:
  - Next state is IDLE and the FIFO is flushed.
  - game_over, win and revealed_cnt clear; ram_we=0 that cycle.
  - A write already completed is not undone. Board re-initialisation is the board generator's job.

## Timing
- Reset values: ram_addr=0, ram_we=0, ram_wdata=0, busy=0, done=0, game_over=0, win=0, revealed_cnt=0, cmd_ready=1. State is IDLE and the FIFO is empty.
- ram_addr, ram_we and ram_wdata are decoded from the state and cur_addr/nb registers. ram_rdata is consumed only in T_CHK and NB_CHK.
- Acceptance at cycle N:
  - T_RD at N+1, T_CHK at N+2.
  - With no flood, done is high at N+3 and cmd_ready returns at N+4.
- Flood: each popped cell costs 17 cycles (POP + 8x2). With P pops, done is high at N+3+17P+1.
- Simultaneous cmd_valid and new_game in IDLE: new_game wins and the command is not accepted.

## Structure
- Shared package minesweeper_pkg holds:
  - GRID_W/GRID_H=16.
  - Cell word bit positions (MINE_B, REV_B, FLAG_B, ADJ_LSB/ADJ_MSB).
  - The state enumeration and the neighbour offset constants.
- One sub-module: cell_fifo, a 256x8 synchronous FIFO with push, pop, empty, and a single-cycle flush.

## Test plan
- Board of all zeros with NUM_MINES=0; reveal (0,0) -> all 256 cells revealed, revealed_cnt=256, win=1, done at N+4356.
- Reveal (5,5) with adjacency 3 -> exactly one write of 0x1A (adj 3 + revealed), revealed_cnt=1, done at N+3.
- Reveal a mine at (2,7) -> game_over=1, cmd_ready=0, and a following cmd_valid is ignored with no RAM write.
- Flag (4,4) twice, then reveal (4,4) -> the flag bit goes 1 then 0, and the reveal then succeeds. Flag then reveal -> no write, done at N+3.
- Flood from corner (15,15) with a flagged zero neighbour -> the flagged cell is not revealed and not expanded; out-of-range slots produce no ram_we.
- new_game asserted mid-flood -> IDLE next cycle, busy=0, revealed_cnt=0, FIFO empty, and the next command is accepted normally.
